// File: rtl/fft_frame_feeder_pkg.sv
// Shared types and helpers for the FFT front end and output shuffle.
package fft_frame_feeder_pkg;

   localparam int unsigned FPT_W = 16;
   localparam int unsigned MAX_N = 10;

   typedef logic signed [FPT_W-1:0] fpt;

   // Reverses the low n bits of idx; bits at and above n come out as zero.
   function automatic logic [MAX_N-1:0] bitrev_N(input logic [MAX_N-1:0] idx,
                                                 input int unsigned n);
      logic [MAX_N-1:0] r;
      r = '0;
      for (int unsigned i = 0; i < MAX_N; i++) begin
         if (i < n) r[i] = idx[n-1-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/fft_frame_feeder_if.sv
// Sample-in handshake and serial FFT-out stream of the frame feeder.
interface fft_frame_feeder_if;
   import fft_frame_feeder_pkg::*;

   fpt   in_data;
   logic in_valid;
   logic in_ready;
   fpt   op;
   logic op_valid;
   logic start_op;

   modport master (output in_data, in_valid, input in_ready, op, op_valid, start_op);
   modport slave  (input in_data, in_valid, output in_ready, op, op_valid, start_op);

endinterface

// File: rtl/fft_pingpong_buf.sv
// Two-bank ping-pong frame store: write counter/bank select and per-bank full flags.
module fft_pingpong_buf
   import fft_frame_feeder_pkg::*;
#(
   parameter int unsigned N = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  fpt           wr_data,
   input  logic         wr_en,
   output logic         wr_ready,
   input  logic         rd_bank,
   input  logic [N-1:0] rd_addr,
   input  logic         rd_clr,
   output fpt           rd_data,
   output logic [1:0]   full
);

   fpt           mem [2][2**N];
   logic [1:0]   full_q, full_d;
   logic         wr_bank_q;
   logic [N-1:0] wr_cnt_q;
   logic         wr_fire;
   logic         wr_last;

   assign wr_ready = !reset && !full_q[wr_bank_q];
   assign wr_fire  = wr_en && wr_ready;
   assign wr_last  = &wr_cnt_q;
   assign rd_data  = mem[rd_bank][rd_addr];
   assign full     = full_q;

   // Reader and writer always sit on different banks, so set and clear never collide.
   always_comb begin
      full_d = full_q;
      if (rd_clr) full_d[rd_bank] = 1'b0;
      if (wr_fire && wr_last) full_d[wr_bank_q] = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         full_q    <= '0;
         wr_bank_q <= 1'b0;
         wr_cnt_q  <= '0;
      end else begin
         full_q <= full_d;
         if (wr_fire) begin
            wr_cnt_q <= wr_cnt_q + 1'b1;
            if (wr_last) wr_bank_q <= ~wr_bank_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_fire) mem[wr_bank_q][wr_cnt_q] <= wr_data;
   end

endmodule

// File: rtl/fft_frame_feeder.sv
// Buffers 2^N-sample frames and replays each as a gap-free stream with a start pulse.
// Define FFT_FEEDER_BITREV_EN to emit each frame in bit-reversed index order.
module fft_frame_feeder
   import fft_frame_feeder_pkg::*;
#(
   parameter int unsigned N   = 3,
   parameter int unsigned GAP = 0
) (
   input  logic                clk,
   input  logic                reset,
   fft_frame_feeder_if.slave   bus,
   output logic                busy,
   output logic [15:0]         frames_sent
);

   typedef enum logic [1:0] {StIdle, StStream, StGap} state_e;

   localparam logic [15:0] GapLast = (GAP > 0) ? 16'(GAP - 1) : 16'd0;

   state_e       st_q, st_d;
   logic [N-1:0] rd_cnt_q, rd_cnt_d;
   logic         rd_bank_q, rd_bank_d;
   logic [15:0]  gap_cnt_q, gap_cnt_d;
   logic [15:0]  frames_q, frames_d;
   fpt           op_q, op_d;
   logic         op_valid_q, op_valid_d;
   logic         start_op_q, start_op_d;
   logic         rd_clr;
   logic [N-1:0] rd_addr;
   logic [1:0]   full;
   fpt           rd_data;

   fft_pingpong_buf #(.N(N)) u_buf (
      .clk      (clk),
      .reset    (reset),
      .wr_data  (bus.in_data),
      .wr_en    (bus.in_valid),
      .wr_ready (bus.in_ready),
      .rd_bank  (rd_bank_q),
      .rd_addr  (rd_addr),
      .rd_clr   (rd_clr),
      .rd_data  (rd_data),
      .full     (full)
   );

`ifdef FFT_FEEDER_BITREV_EN
   logic [MAX_N-1:0] rev;
   always_comb begin
      rev     = bitrev_N(MAX_N'(rd_cnt_q), N);
      rd_addr = rev[N-1:0];
   end
`else
   assign rd_addr = rd_cnt_q;
`endif

   always_comb begin
      st_d       = st_q;
      rd_cnt_d   = rd_cnt_q;
      rd_bank_d  = rd_bank_q;
      gap_cnt_d  = gap_cnt_q;
      frames_d   = frames_q;
      op_d       = op_q;
      op_valid_d = 1'b0;
      start_op_d = 1'b0;
      rd_clr     = 1'b0;
      unique case (st_q)
         StIdle: begin
            if (full[rd_bank_q]) begin
               st_d     = StStream;
               rd_cnt_d = '0;
            end
         end
         StStream: begin
            op_d       = rd_data;
            op_valid_d = 1'b1;
            start_op_d = (rd_cnt_q == '0);
            rd_cnt_d   = rd_cnt_q + 1'b1;
            if (&rd_cnt_q) begin
               rd_clr    = 1'b1;
               rd_bank_d = ~rd_bank_q;
               frames_d  = frames_q + 16'd1;
               if (GAP > 0) begin
                  st_d      = StGap;
                  gap_cnt_d = '0;
               end else if (full[~rd_bank_q]) begin
                  st_d = StStream;
               end else begin
                  st_d = StIdle;
               end
            end
         end
         StGap: begin
            gap_cnt_d = gap_cnt_q + 16'd1;
            // Final gap cycle folds in the idle check so the gap is exactly GAP cycles.
            if (gap_cnt_q == GapLast) begin
               st_d     = full[rd_bank_q] ? StStream : StIdle;
               rd_cnt_d = '0;
            end
         end
         default: st_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st_q       <= StIdle;
         rd_cnt_q   <= '0;
         rd_bank_q  <= 1'b0;
         gap_cnt_q  <= '0;
         frames_q   <= '0;
         op_q       <= '0;
         op_valid_q <= 1'b0;
         start_op_q <= 1'b0;
      end else begin
         st_q       <= st_d;
         rd_cnt_q   <= rd_cnt_d;
         rd_bank_q  <= rd_bank_d;
         gap_cnt_q  <= gap_cnt_d;
         frames_q   <= frames_d;
         op_q       <= op_d;
         op_valid_q <= op_valid_d;
         start_op_q <= start_op_d;
      end
   end

   assign bus.op       = op_q;
   assign bus.op_valid = op_valid_q;
   assign bus.start_op = start_op_q;
   assign busy         = (st_q != StIdle);
   assign frames_sent  = frames_q;

endmodule
